// File: rtl/ks_mac_pkg.sv
// ks_mac_pkg: shared constants, state type and helpers
// for the Kogge-Stone adder datapath and its arbiter.
package ks_mac_pkg;

  localparam int KS_W   = 25;
  localparam int KS_LAT = 6;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } ks_state_e;

  // Ceiling log2, never below 1 so it can size an index.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ks_arb_fifo.sv
// ks_arb_fifo: small per-requester result FIFO.
// Head is read from storage only; a push is never bypassed.
module ks_arb_fifo
  import ks_mac_pkg::*;
#(
  parameter int DW    = 26,
  parameter int DEPTH = 4
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o,
  output logic          empty_o,
  output logic          full_o
);

  localparam int AW = clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_q;
  logic [AW:0]   rd_q;
  logic          do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout_o  = mem_q[rd_q[AW-1:0]];
  assign do_pop  = pop_i && !empty_o;

  // Storage and wrap-by-overflow pointers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q[AW-1:0]] <= din_i;
        wr_q <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// File: rtl/ks_adder_arbiter.sv
// ks_adder_arbiter: round-robin share of one pipelined KS adder.
// Define KS_ARB_STATS_EN to add stat_busy/stat_stall counters.
module ks_adder_arbiter
  import ks_mac_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int W     = KS_W,
  parameter int LAT   = KS_LAT,
  parameter int DEPTH = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_sign,
  output logic              ks_valid,
  output logic [W-1:0]      ks_a,
  output logic [W-1:0]      ks_b,
  output logic              ks_sign,
  input  logic [W-1:0]      ks_sum,
  input  logic              ks_sign_o,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [NREQ*W-1:0] rsp_sum,
  output logic [NREQ-1:0]   rsp_sign,
  input  logic              flush,
  output logic              idle
`ifdef KS_ARB_STATS_EN
  ,
  output logic [31:0]       stat_busy,
  output logic [31:0]       stat_stall
`endif
);

  localparam int IW = clog2(NREQ);
  localparam int CW = clog2(DEPTH) + 1;

  ks_state_e       state_q, state_d;
  logic [IW-1:0]   rr_q;
  logic [CW-1:0]   credit_q [NREQ];

  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] pop;
  logic [NREQ-1:0] push;
  logic [NREQ-1:0] full;
  logic [NREQ-1:0] empty;
  logic            gnt_any;
  logic [IW-1:0]   gnt_id;
  logic [W-1:0]    sel_a, sel_b;
  logic            sel_s;

  logic            iss_v_q;
  logic [IW-1:0]   iss_id_q;
  logic [W-1:0]    iss_a_q, iss_b_q;
  logic            iss_s_q;

  logic [LAT-1:0]  tag_v_q;
  logic [IW-1:0]   tag_id_q [LAT];
  logic            busy;

  assign ks_valid  = iss_v_q;
  assign ks_a      = iss_a_q;
  assign ks_b      = iss_b_q;
  assign ks_sign   = iss_s_q;
  assign req_ready = gnt;
  assign busy      = iss_v_q || (|tag_v_q);
  assign idle      = (state_q == IDLE) && !busy;

  // Eligibility: valid, room reserved downstream, not draining.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req_valid[i] &&
                (credit_q[i] < CW'(DEPTH)) &&
                (state_q != DRAIN) && !flush;
    end
  end

  // Round-robin pick: first eligible at or after rr_q.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    sel_a   = '0;
    sel_b   = '0;
    sel_s   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(rr_q) + k) % NREQ;
      if (!gnt_any && elig[idx]) begin
        gnt_any   = 1'b1;
        gnt[idx]  = 1'b1;
        gnt_id    = IW'(idx);
        sel_a     = req_a[idx*W +: W];
        sel_b     = req_b[idx*W +: W];
        sel_s     = req_sign[idx];
      end
    end
  end

  // Issue register to adder stage 1 plus pointer advance.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      iss_v_q  <= 1'b0;
      iss_id_q <= '0;
      iss_a_q  <= '0;
      iss_b_q  <= '0;
      iss_s_q  <= 1'b0;
      rr_q     <= '0;
    end else begin
      iss_v_q <= gnt_any;
      if (gnt_any) begin
        iss_id_q <= gnt_id;
        iss_a_q  <= sel_a;
        iss_b_q  <= sel_b;
        iss_s_q  <= sel_s;
        rr_q     <= IW'((int'(gnt_id) + 1) % NREQ);
      end
    end
  end

  // Ownership tags ride alongside the adder pipeline.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tag_v_q <= '0;
      for (int k = 0; k < LAT; k++) tag_id_q[k] <= '0;
    end else begin
      tag_v_q     <= {tag_v_q[LAT-2:0], iss_v_q};
      tag_id_q[0] <= iss_id_q;
      for (int k = 1; k < LAT; k++) tag_id_q[k] <= tag_id_q[k-1];
    end
  end

  // Credits: in-flight plus buffered results per requester.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREQ; i++) credit_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        unique case ({gnt[i], pop[i]})
          2'b10:   credit_q[i] <= credit_q[i] + 1'b1;
          2'b01:   credit_q[i] <= credit_q[i] - 1'b1;
          default: credit_q[i] <= credit_q[i];
        endcase
      end
    end
  end

  // Control state register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state: run while work exists, drain on flush.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (|req_valid && !flush) state_d = RUN;
      RUN: begin
        if (flush)                         state_d = DRAIN;
        else if (!busy && !(|req_valid))   state_d = IDLE;
      end
      DRAIN: if (!busy && !flush) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_fifo
    logic [W:0] dout;

    assign push[i] = tag_v_q[LAT-1] &&
                     (tag_id_q[LAT-1] == IW'(i));
    assign pop[i]  = rsp_valid[i] && rsp_ready[i];

    ks_arb_fifo #(
      .DW    (W + 1),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clock   (clock),
      .resetn  (resetn),
      .push_i  (push[i]),
      .pop_i   (pop[i]),
      .din_i   ({ks_sign_o, ks_sum}),
      .dout_o  (dout),
      .empty_o (empty[i]),
      .full_o  (full[i])
    );

    assign rsp_valid[i]        = !empty[i];
    assign rsp_sum[i*W +: W]   = dout[W-1:0];
    assign rsp_sign[i]         = dout[W];
  end

  // Credits reserve a slot at grant, so a write never meets a full FIFO.
  a_no_overflow: assert property (
    @(posedge clock) disable iff (!resetn) ((push & full) == '0)
  );

`ifdef KS_ARB_STATS_EN
  // Saturating utilisation and stall counters.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stat_busy  <= '0;
      stat_stall <= '0;
    end else begin
      if (iss_v_q && (stat_busy != '1))
        stat_busy <= stat_busy + 1'b1;
      if ((|req_valid) && !gnt_any && (stat_stall != '1))
        stat_stall <= stat_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ks_adder_arbiter.sv
// tb_ks_adder_arbiter: directed checks of grant order, credits,
// flush drain and reset against a behavioural LAT-stage adder.
module tb_ks_adder_arbiter;

  localparam int NREQ  = 2;
  localparam int W     = 25;
  localparam int LAT   = 6;
  localparam int DEPTH = 4;

  logic              clock = 1'b0;
  logic              resetn = 1'b0;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_sign;
  logic              ks_valid;
  logic [W-1:0]      ks_a;
  logic [W-1:0]      ks_b;
  logic              ks_sign;
  logic [W-1:0]      ks_sum;
  logic              ks_sign_o;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [NREQ*W-1:0] rsp_sum;
  logic [NREQ-1:0]   rsp_sign;
  logic              flush;
  logic              idle;
`ifdef KS_ARB_STATS_EN
  logic [31:0]       stat_busy;
  logic [31:0]       stat_stall;
`endif

  always #5 clock = ~clock;

  // Adder model: sum (or difference) appears LAT cycles after issue.
  logic [W-1:0]   pipe_s [LAT];
  logic [LAT-1:0] pipe_g;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < LAT; k++) pipe_s[k] <= '0;
      pipe_g <= '0;
    end else begin
      pipe_s[0] <= ks_sign ? (ks_a - ks_b) : (ks_a + ks_b);
      pipe_g    <= {pipe_g[LAT-2:0], ks_sign};
      for (int k = 1; k < LAT; k++) pipe_s[k] <= pipe_s[k-1];
    end
  end

  assign ks_sum    = pipe_s[LAT-1];
  assign ks_sign_o = pipe_g[LAT-1];

  ks_adder_arbiter #(
    .NREQ  (NREQ),
    .W     (W),
    .LAT   (LAT),
    .DEPTH (DEPTH)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sign  (req_sign),
    .ks_valid  (ks_valid),
    .ks_a      (ks_a),
    .ks_b      (ks_b),
    .ks_sign   (ks_sign),
    .ks_sum    (ks_sum),
    .ks_sign_o (ks_sign_o),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_sign  (rsp_sign),
    .flush     (flush),
    .idle      (idle)
`ifdef KS_ARB_STATS_EN
    ,
    .stat_busy  (stat_busy),
    .stat_stall (stat_stall)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cnt;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clock);
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic s);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_sign[i]     = s;
  endtask

  initial begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sign  = '0;
    rsp_ready = '0;
    flush     = 1'b0;
    tick;
    tick;
    check("rst_idle", 32'(idle), 1);
    check("rst_ksv", 32'(ks_valid), 0);
    check("rst_rspv", 32'(rsp_valid), 0);
    check("rst_rdy", 32'(req_ready), 0);
    resetn = 1'b1;
    tick;

    // Fairness: both requesters held for 8 cycles.
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) begin
        check("fair_ksv", 32'(ks_valid), 1);
        check("fair_ksa", 32'(ks_a),
              ((k - 1) % 2 == 0) ? 32'h100 + k - 1 : 32'h200 + k - 1);
      end
      if (k < 8) begin
        req_valid = 2'b11;
        set_req(0, W'(32'h100 + k), W'(k), 1'b0);
        set_req(1, W'(32'h200 + k), W'(k), 1'b0);
        #1;
        check("fair_rdy", 32'(req_ready),
              (k % 2 == 0) ? 32'h1 : 32'h2);
        tick;
      end else begin
        req_valid = '0;
      end
    end
    repeat (8) tick;
    check("fair_rspv", 32'(rsp_valid), 3);
    for (int j = 0; j < 4; j++) begin
      check("fair_res0", 32'(rsp_sum[0 +: W]), 32'h100 + 4 * j);
      check("fair_res1", 32'(rsp_sum[W +: W]), 32'h202 + 4 * j);
      rsp_ready = 2'b11;
      tick;
    end
    rsp_ready = '0;
    check("fair_empty", 32'(rsp_valid), 0);

    // Single issue on requester 0.
    req_valid = 2'b01;
    set_req(0, 25'h0000010, 25'h0000005, 1'b0);
    #1;
    check("si_rdy", 32'(req_ready), 1);
    tick;
    check("si_ksv", 32'(ks_valid), 1);
    check("si_ksa", 32'(ks_a), 32'h10);
    check("si_ksb", 32'(ks_b), 32'h5);
    req_valid = '0;
    tick;
    check("si_ksv0", 32'(ks_valid), 0);
    repeat (5) tick;
    check("si_early", 32'(rsp_valid), 0);
    tick;
    check("si_rspv", 32'(rsp_valid), 1);
    check("si_sum", 32'(rsp_sum[0 +: W]), 32'h15);
    check("si_sign", 32'(rsp_sign[0]), 0);
    rsp_ready = 2'b01;
    tick;
    rsp_ready = '0;
    check("si_pop", 32'(rsp_valid), 0);
    tick;
    check("si_idle", 32'(idle), 1);

    // Backpressure: no pops, requester 0 held.
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      req_valid = 2'b01;
      set_req(0, W'(32'h40 + cnt), '0, 1'b0);
      #1;
      if (req_ready[0]) cnt++;
      tick;
    end
    check("bp_grants", 32'(cnt), DEPTH);
    #1;
    check("bp_stop", 32'(req_ready), 0);
    check("bp_rspv", 32'(rsp_valid), 1);
    check("bp_head", 32'(rsp_sum[0 +: W]), 32'h40);
    rsp_ready = 2'b01;
    #1;
    check("bp_popcyc", 32'(req_ready), 0);
    tick;
    rsp_ready = '0;
    set_req(0, 25'h44, '0, 1'b0);
    #1;
    check("bp_regrant", 32'(req_ready), 1);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (req_ready[0]) cnt++;
      tick;
    end
    check("bp_onemore", 32'(cnt), 1);
    req_valid = '0;
    for (int j = 0; j < 4; j++) begin
      check("bp_res", 32'(rsp_sum[0 +: W]), 32'h41 + j);
      rsp_ready = 2'b01;
      tick;
    end
    rsp_ready = '0;
    check("bp_empty", 32'(rsp_valid), 0);

    // Same-cycle grant and pop on requester 1 at full credit.
    for (int j = 0; j < 4; j++) begin
      req_valid = 2'b10;
      set_req(1, W'(32'h400 + j), '0, 1'b0);
      #1;
      check("cr_fill", 32'(req_ready), 2);
      tick;
    end
    req_valid = '0;
    repeat (9) tick;
    for (int m = 0; m < 6; m++) begin
      req_valid = 2'b10;
      set_req(1, W'(32'h300 + m), 25'h1, 1'b0);
      rsp_ready = (m < 4) ? 2'b10 : 2'b00;
      if (m < 4)
        check("cr_head", 32'(rsp_sum[W +: W]), 32'h400 + m);
      #1;
      check("cr_rdy", 32'(req_ready),
            (m == 0 || m == 5) ? 32'h0 : 32'h2);
      tick;
    end
    req_valid = '0;
    rsp_ready = '0;
    repeat (9) tick;
    for (int j = 0; j < 4; j++) begin
      check("cr_rspv", 32'(rsp_valid), 2);
      check("cr_res", 32'(rsp_sum[W +: W]), 32'h302 + j);
      rsp_ready = 2'b10;
      tick;
    end
    rsp_ready = '0;
    check("cr_empty", 32'(rsp_valid), 0);

    // Flush with three issues in flight.
    for (int k = 0; k < 3; k++) begin
      req_valid = 2'b01;
      set_req(0, W'(32'h500 + k), 25'h10, (k == 1));
      #1;
      check("fl_rdy", 32'(req_ready), 1);
      tick;
    end
    flush = 1'b1;
    #1;
    check("fl_nogrant", 32'(req_ready), 0);
    check("fl_busy", 32'(idle), 0);
    tick;
    #1;
    check("fl_nogrant2", 32'(req_ready), 0);
    tick;
    flush     = 1'b0;
    req_valid = '0;
    repeat (4) tick;
    check("fl_notidle", 32'(idle), 0);
    repeat (3) tick;
    check("fl_idle", 32'(idle), 1);
    check("fl_rspv", 32'(rsp_valid), 1);
    check("fl_res0", 32'(rsp_sum[0 +: W]), 32'h510);
    check("fl_sgn0", 32'(rsp_sign[0]), 0);
    rsp_ready = 2'b01;
    tick;
    check("fl_res1", 32'(rsp_sum[0 +: W]), 32'h4f1);
    check("fl_sgn1", 32'(rsp_sign[0]), 1);
    tick;
    rsp_ready = '0;
    check("fl_res2", 32'(rsp_sum[0 +: W]), 32'h512);

    // Asynchronous reset in the third cycle of a burst.
    req_valid = 2'b11;
    set_req(0, 25'h600, 25'h1, 1'b0);
    set_req(1, 25'h700, 25'h1, 1'b0);
    #1;
    check("ar_rdy1", 32'(req_ready), 2);
    tick;
    #1;
    check("ar_rdy2", 32'(req_ready), 1);
    tick;
    #1;
    check("ar_rdy3", 32'(req_ready), 2);
    check("ar_pre_rspv", 32'(rsp_valid), 1);
    check("ar_pre_ksv", 32'(ks_valid), 1);
    #1;
    resetn = 1'b0;
    #1;
    check("ar_rspv", 32'(rsp_valid), 0);
    check("ar_idle", 32'(idle), 1);
    check("ar_ksv", 32'(ks_valid), 0);
    check("ar_rr", 32'(req_ready), 1);
    tick;
    resetn    = 1'b1;
    req_valid = 2'b01;
    set_req(0, 25'h123, 25'h10, 1'b0);
    #1;
    check("ar_post_rdy", 32'(req_ready), 1);
    tick;
    req_valid = '0;
    repeat (6) tick;
    check("ar_post_early", 32'(rsp_valid), 0);
    tick;
    check("ar_post_rspv", 32'(rsp_valid), 1);
    check("ar_post_sum", 32'(rsp_sum[0 +: W]), 32'h133);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
